cpu_phase_sequencer: RTL and testbench
======================================

// Module: cpu_phase_sequencer
// PURPOSE
//  Instruction fetch and phase sequencer upstream of the group decoders (load/store, jump, ALU, system).
//  Fetches a 16-bit word at PC, latches it into the instruction register and drives the one-hot
//  FETCH/DECODE/EXECUTE/COMMIT strobes the decoders consume.
//  Stalls on memory wait states and halts on HALT or bus timeout.
// PARAMETERS
//  ADDR_WIDTH   16       instruction address width
//  MAX_WAIT     15       max wait cycles per bus access before timeout (1..255)
//  RESET_INSTR  16'h0000 instruction register value after reset (NOP)
// PORTS
//  CLK          in   1   system clock, rising edge
//  RESET        in   1   asynchronous, active-high reset
//  PC           in   AW  current program counter (from PC unit)
//  IADDR        out  AW  instruction fetch address (= PC while IREQ)
//  IREQ         out  1   instruction fetch request
//  IRDY         in   1   instruction memory ready; IDATA valid
//  IDATA        in   16  instruction memory read data
//  MEM_REQ      in   1   data access requested by the decoder during EXECUTE
//  MEM_RDY      in   1   data memory ready
//  HALT_REQ     in   1   halt request (system group), sampled in COMMIT only
//  RUN          in   1   resume pulse, honoured in HALTED only
//  INSTRUCTION  out  16  instruction register, stable DECODE..COMMIT
//  FETCH        out  1   phase strobe (one-hot with the following three)
//  DECODE       out  1   phase strobe
//  EXECUTE      out  1   phase strobe
//  COMMIT       out  1   phase strobe
//  PC_INC       out  1   one-cycle pulse during COMMIT: advance PC
//  HALTED       out  1   sequencer halted
//  BUS_ERR      out  1   sticky timeout flag
// BEHAVIOUR
//  - Reset: state=S_FETCH; FETCH=1, IREQ=1; other strobes 0; PC_INC=0, HALTED=0, BUS_ERR=0;
//    INSTRUCTION=RESET_INSTR; wait counter=0. All outputs decode from the registered state.
//  - S_FETCH: IREQ=1, IADDR=PC. IRDY=1 latches IDATA into INSTRUCTION, goes to S_DECODE next edge.
//    IRDY in the first FETCH cycle is a zero-wait fetch: FETCH lasts 1 cycle.
//  - S_DECODE: lasts exactly 1 cycle, then S_EXECUTE.
//  - S_EXECUTE: MEM_REQ=0 or (MEM_REQ & MEM_RDY) goes to S_COMMIT; otherwise stay and count waits.
//  - S_COMMIT: PC_INC=1 for this 1 cycle. Next state is S_HALTED if HALT_REQ, else S_FETCH.
//  - S_HALTED: all strobes 0, IREQ=0, HALTED=1. RUN=1 goes to S_FETCH and clears BUS_ERR.
//  - Timeout: the wait counter clears on entry to FETCH/EXECUTE and counts each stalled cycle.
//    When the count reaches MAX_WAIT with still no ready: BUS_ERR<=1, go to S_HALTED, PC_INC is not
//    asserted, INSTRUCTION holds its old value. A ready on the MAX_WAIT-th cycle wins over timeout.
//  - Minimum instruction time is 4 cycles (F,D,E,C). No overlap between instructions.
//  - HALT_REQ outside COMMIT and RUN outside HALTED are ignored. IRDY/MEM_RDY outside their phase
//    are ignored.
//  - RESET asserted mid-instruction aborts it immediately to the reset state. PC is untouched
//    because no PC_INC is issued.
// CONFIGURATION
//  - SEQ_SINGLE_STEP_EN defined: adds input STEP_MODE (1 bit). When STEP_MODE=1, COMMIT always goes
//    to S_HALTED, so each RUN pulse executes exactly one instruction.
//  - SEQ_SINGLE_STEP_EN undefined: the port is absent and behaviour equals STEP_MODE=0.
// STRUCTURE
//  - Shared constants.v holds state encodings `SEQ_S_FETCH, `SEQ_S_DECODE, `SEQ_S_EXECUTE,
//    `SEQ_S_COMMIT, `SEQ_S_HALTED (3-bit) and `NOP_INSTR.
//  - One sub-module, seq_wait_timer: clear/enable/terminal-count counter, width $clog2(MAX_WAIT+1).
// TESTING
//  1. Reset, then IRDY tied 1, IDATA=16'h5123, MEM_REQ=0 -> F,D,E,C each 1 cycle,
//     INSTRUCTION=16'h5123 from DECODE, PC_INC pulses every 4th cycle.
//  2. IRDY delayed 3 cycles -> FETCH held 4 cycles, IREQ held, IADDR=PC throughout; then D,E,C.
//  3. MEM_REQ=1, MEM_RDY after 2 cycles -> EXECUTE lasts 3 cycles, one PC_INC.
//  4. MEM_REQ=1, MEM_RDY=0 forever, MAX_WAIT=15 -> BUS_ERR=1 and HALTED=1 after 15 stalled cycles,
//     no PC_INC. RUN -> BUS_ERR=0, FETCH=1.
//  5. HALT_REQ=1 in COMMIT -> HALTED next cycle. RUN held 1 during EXECUTE -> no effect.
//     RUN pulse while HALTED -> FETCH.
//  6. RESET asserted during EXECUTE -> async return to FETCH=1, INSTRUCTION=16'h0000.
//     With SEQ_SINGLE_STEP_EN and STEP_MODE=1 -> exactly one PC_INC per RUN pulse.

Source files
------------

// File: rtl/cpu_phase_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// cpu_phase_sequencer_pkg : shared state encodings and constants.
// Rev 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

package cpu_phase_sequencer_pkg;

  typedef enum logic [2:0] {
    S_FETCH   = 3'd0,
    S_DECODE  = 3'd1,
    S_EXECUTE = 3'd2,
    S_COMMIT  = 3'd3,
    S_HALTED  = 3'd4
  } seq_state_e;

  localparam logic [15:0] NOP_INSTR = 16'h0000;

endpackage

`default_nettype wire

// File: rtl/cpu_phase_sequencer_wait_timer.sv
// ---------------------------------------------------------------------------
// cpu_phase_sequencer_wait_timer : clear/enable stall counter with terminal count.
// Rev 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module cpu_phase_sequencer_wait_timer
  import cpu_phase_sequencer_pkg::*;
#(
  parameter int MAX_WAIT = 15
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  localparam int CW = $clog2(MAX_WAIT + 1);
  // tc marks the MAX_WAIT-th stalled cycle, so the count holds MAX_WAIT-1 then
  localparam logic [CW-1:0] TC_VAL = CW'(MAX_WAIT - 1);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (en_i && (count_q != TC_VAL)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign tc_o = (count_q == TC_VAL);

endmodule

`default_nettype wire

// File: rtl/cpu_phase_sequencer.sv
// ---------------------------------------------------------------------------
// cpu_phase_sequencer : instruction fetch and F/D/E/C phase sequencer with
// wait-state timeout. Optional macro SEQ_SINGLE_STEP_EN adds step_mode_i.
// Rev 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module cpu_phase_sequencer
  import cpu_phase_sequencer_pkg::*;
#(
  parameter int              ADDR_WIDTH  = 16,
  parameter int              MAX_WAIT    = 15,
  parameter logic [15:0]     RESET_INSTR = NOP_INSTR
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
`ifdef SEQ_SINGLE_STEP_EN
  input  logic                  step_mode_i,
`endif
  input  logic [ADDR_WIDTH-1:0] pc_i,
  output logic [ADDR_WIDTH-1:0] iaddr_o,
  output logic                  ireq_o,
  input  logic                  irdy_i,
  input  logic [15:0]           idata_i,
  input  logic                  mem_req_i,
  input  logic                  mem_rdy_i,
  input  logic                  halt_req_i,
  input  logic                  run_i,
  output logic [15:0]           instruction_o,
  output logic                  fetch_o,
  output logic                  decode_o,
  output logic                  execute_o,
  output logic                  commit_o,
  output logic                  pc_inc_o,
  output logic                  halted_o,
  output logic                  bus_err_o
);

  seq_state_e  state_q, state_d;
  logic [15:0] instr_q, instr_d;
  logic        bus_err_q, bus_err_d;
  logic        stall;
  logic        wait_tc;
  logic        step_en;

`ifdef SEQ_SINGLE_STEP_EN
  assign step_en = step_mode_i;
`else
  assign step_en = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    instr_d   = instr_q;
    bus_err_d = bus_err_q;
    stall     = 1'b0;
    unique case (state_q)
      S_FETCH: begin
        if (irdy_i) begin
          instr_d = idata_i;
          state_d = S_DECODE;
        end else begin
          stall = 1'b1;
        end
      end
      S_DECODE:  state_d = S_EXECUTE;
      S_EXECUTE: begin
        if (!mem_req_i || mem_rdy_i) begin
          state_d = S_COMMIT;
        end else begin
          stall = 1'b1;
        end
      end
      S_COMMIT:  state_d = (halt_req_i || step_en) ? S_HALTED : S_FETCH;
      S_HALTED: begin
        if (run_i) begin
          state_d   = S_FETCH;
          bus_err_d = 1'b0;
        end
      end
      default:   state_d = S_FETCH;
    endcase
    // A ready on the terminal cycle already left the stall branch above
    if (stall && wait_tc) begin
      state_d   = S_HALTED;
      bus_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= S_FETCH;
      instr_q   <= RESET_INSTR;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      instr_q   <= instr_d;
      bus_err_q <= bus_err_d;
    end
  end

  cpu_phase_sequencer_wait_timer #(
    .MAX_WAIT (MAX_WAIT)
  ) u_wait_timer (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .clr_i (!stall),
    .en_i  (stall),
    .tc_o  (wait_tc)
  );

  assign fetch_o       = (state_q == S_FETCH);
  assign decode_o      = (state_q == S_DECODE);
  assign execute_o     = (state_q == S_EXECUTE);
  assign commit_o      = (state_q == S_COMMIT);
  assign halted_o      = (state_q == S_HALTED);
  assign pc_inc_o      = commit_o;
  assign ireq_o        = fetch_o;
  assign iaddr_o       = fetch_o ? pc_i : '0;
  assign instruction_o = instr_q;
  assign bus_err_o     = bus_err_q;

endmodule

`default_nettype wire

// File: tb/tb_cpu_phase_sequencer.sv
// ---------------------------------------------------------------------------
// tb_cpu_phase_sequencer : randomized bench with an instruction-level model.
// Rev 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module tb_cpu_phase_sequencer;

  localparam int AW = 16;
  localparam int MW = 15;
  localparam int PH_F = 0, PH_D = 1, PH_E = 2, PH_C = 3, PH_H = 4;

  typedef struct {
    logic        irdy;
    logic [15:0] idata;
    logic        mem_req;
    logic        mem_rdy;
    logic        halt_req;
    logic        run;
    int          ph;
    logic [15:0] instr;
    logic        berr;
  } cyc_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          step_mode;
  logic [AW-1:0] pc_in;
  logic [AW-1:0] iaddr;
  logic          ireq, irdy, mem_req, mem_rdy, halt_req, run;
  logic [15:0]   idata, instruction;
  logic          fetch, decode, execute, commit, pc_inc, halted, bus_err;

  cyc_t          q[$];
  int            checks = 0;
  int            errors = 0;
  logic [15:0]   m_instr;
  logic          m_berr;
  logic          m_step;
  logic [AW-1:0] pc;

  always #5 clk = ~clk;

  cpu_phase_sequencer #(
    .ADDR_WIDTH  (AW),
    .MAX_WAIT    (MW),
    .RESET_INSTR (16'h0000)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
`ifdef SEQ_SINGLE_STEP_EN
    .step_mode_i   (step_mode),
`endif
    .pc_i          (pc_in),
    .iaddr_o       (iaddr),
    .ireq_o        (ireq),
    .irdy_i        (irdy),
    .idata_i       (idata),
    .mem_req_i     (mem_req),
    .mem_rdy_i     (mem_rdy),
    .halt_req_i    (halt_req),
    .run_i         (run),
    .instruction_o (instruction),
    .fetch_o       (fetch),
    .decode_o      (decode),
    .execute_o     (execute),
    .commit_o      (commit),
    .pc_inc_o      (pc_inc),
    .halted_o      (halted),
    .bus_err_o     (bus_err)
  );

  // Random values on every input the current phase must ignore
  function automatic cyc_t noise(int ph);
    cyc_t c;
    c.irdy     = 1'($urandom);
    c.idata    = 16'($urandom);
    c.mem_req  = 1'($urandom);
    c.mem_rdy  = 1'($urandom);
    c.halt_req = 1'($urandom);
    c.run      = (ph == PH_H) ? 1'b0 : 1'($urandom);
    c.ph       = ph;
    c.instr    = m_instr;
    c.berr     = m_berr;
    return c;
  endfunction

  function automatic void plan_halted(int hold);
    cyc_t c;
    for (int i = 0; i <= hold; i++) begin
      c     = noise(PH_H);
      c.run = (i == hold);
      q.push_back(c);
    end
    m_berr = 1'b0;
  endfunction

  // lf/le = stalled cycles before ready; >= MW means the access times out
  function automatic void plan_instr(int lf, bit mreq, int le, bit halt, int hold,
                                     logic [15:0] word);
    cyc_t c;
    int   n;
    n = (lf < MW) ? lf + 1 : MW;
    for (int i = 0; i < n; i++) begin
      c      = noise(PH_F);
      c.irdy = (i == lf);
      if (i == lf) c.idata = word;
      q.push_back(c);
    end
    if (lf >= MW) begin
      m_berr = 1'b1;
      plan_halted(hold);
      return;
    end
    m_instr = word;
    q.push_back(noise(PH_D));
    n = !mreq ? 1 : ((le < MW) ? le + 1 : MW);
    for (int i = 0; i < n; i++) begin
      c         = noise(PH_E);
      c.mem_req = mreq;
      if (mreq) c.mem_rdy = (i == le);
      q.push_back(c);
    end
    if (mreq && le >= MW) begin
      m_berr = 1'b1;
      plan_halted(hold);
      return;
    end
    c          = noise(PH_C);
    c.halt_req = halt;
    q.push_back(c);
    if (halt || m_step) plan_halted(hold);
  endfunction

  task automatic test_reset();
    rst = 1'b1; irdy = 1'b0; idata = '0; mem_req = 1'b0; mem_rdy = 1'b0;
    halt_req = 1'b0; run = 1'b0; step_mode = 1'b0; pc = 16'h0100; pc_in = pc;
    m_instr = 16'h0000; m_berr = 1'b0; m_step = 1'b0;
    #1;
    checks++;
    if ({fetch, decode, execute, commit, halted} !== 5'b10000) begin
      errors++;
      $display("FAIL reset_strobes: got %b expected 10000", {fetch, decode, execute, commit, halted});
    end
    checks++;
    if ({ireq, pc_inc, bus_err} !== 3'b100) begin
      errors++;
      $display("FAIL reset_ireq_pcinc_berr: got %b expected 100", {ireq, pc_inc, bus_err});
    end
    checks++;
    if (instruction !== 16'h0000) begin
      errors++;
      $display("FAIL reset_instruction: got %h expected 0000", instruction);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_phase_sequences(input int n_random, input bit directed);
    logic [6:0] obs, exp;
    int lf, le;
    if (directed) begin
      repeat (3) plan_instr(0, 1'b0, 0, 1'b0, 0, 16'h5123);
      plan_instr(3, 1'b0, 0, 1'b0, 0, 16'h1A2B);
      plan_instr(0, 1'b1, 2, 1'b0, 0, 16'h2C3D);
      plan_instr(0, 1'b1, MW + 5, 1'b0, 1, 16'h3E4F);
      plan_instr(MW, 1'b0, 0, 1'b0, 0, 16'h4A5B);
      plan_instr(MW - 1, 1'b1, MW - 1, 1'b0, 0, 16'h5C6D);
      plan_instr(0, 1'b0, 0, 1'b1, 2, 16'h6789);
      plan_instr(1, 1'b1, 0, 1'b1, 0, 16'h7ABC);
    end
    for (int n = 0; n < n_random; n++) begin
      lf = ($urandom_range(0, 7) == 0) ? int'($urandom_range(MW - 2, MW + 2))
                                       : int'($urandom_range(0, 3));
      le = ($urandom_range(0, 7) == 0) ? int'($urandom_range(MW - 2, MW + 2))
                                       : int'($urandom_range(0, 3));
      plan_instr(lf, 1'($urandom), le, ($urandom_range(0, 3) == 0),
                 int'($urandom_range(0, 2)), 16'($urandom));
    end
    foreach (q[k]) begin
      irdy = q[k].irdy; idata = q[k].idata; mem_req = q[k].mem_req;
      mem_rdy = q[k].mem_rdy; halt_req = q[k].halt_req; run = q[k].run; pc_in = pc;
      #1;
      obs = {fetch, decode, execute, commit, halted, ireq, pc_inc};
      exp = {5'b10000 >> q[k].ph, q[k].ph == PH_F, q[k].ph == PH_C};
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL phase cycle %0d: got FDECH/ireq/pcinc %b expected %b", k, obs, exp);
      end
      checks++;
      if (instruction !== q[k].instr) begin
        errors++;
        $display("FAIL instruction cycle %0d: got %h expected %h", k, instruction, q[k].instr);
      end
      checks++;
      if (bus_err !== q[k].berr) begin
        errors++;
        $display("FAIL bus_err cycle %0d: got %b expected %b", k, bus_err, q[k].berr);
      end
      if (q[k].ph == PH_F) begin
        checks++;
        if (iaddr !== pc) begin
          errors++;
          $display("FAIL iaddr cycle %0d: got %h expected %h", k, iaddr, pc);
        end
      end
      @(posedge clk);
      if (q[k].ph == PH_C) pc = pc + 1'b1;
      @(negedge clk);
    end
    q.delete();
  endtask

  task automatic test_async_reset();
    irdy = 1'b1; idata = 16'hABCD; mem_req = 1'b1; mem_rdy = 1'b0;
    halt_req = 1'b0; run = 1'b0; pc_in = pc;
    repeat (2) begin
      @(posedge clk);
      @(negedge clk);
    end
    checks++;
    if (execute !== 1'b1 || instruction !== 16'hABCD) begin
      errors++;
      $display("FAIL pre_reset_execute: got exec=%b instr=%h expected exec=1 instr=abcd",
               execute, instruction);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({fetch, execute, pc_inc, halted, bus_err} !== 5'b10000) begin
      errors++;
      $display("FAIL async_reset_strobes: got %b expected 10000",
               {fetch, execute, pc_inc, halted, bus_err});
    end
    checks++;
    if (instruction !== 16'h0000) begin
      errors++;
      $display("FAIL async_reset_instruction: got %h expected 0000", instruction);
    end
    @(negedge clk);
    rst = 1'b0;
    m_instr = 16'h0000;
    m_berr  = 1'b0;
  endtask

`ifdef SEQ_SINGLE_STEP_EN
  task automatic test_single_step();
    step_mode = 1'b1;
    m_step    = 1'b1;
    test_phase_sequences(8, 1'b0);
    step_mode = 1'b0;
    m_step    = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_phase_sequences(40, 1'b1);
    test_async_reset();
    test_phase_sequences(10, 1'b0);
`ifdef SEQ_SINGLE_STEP_EN
    test_single_step();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
